tcp_payload_packer: RTL
=======================

// Module: tcp_payload_packer
// PURPOSE
//  Upstream feeder of the GMII/MII TCP packet sender. Packs a byte stream (camera/app data) big-endian into
//  32-bit words, writes them into the sender's payload RAM, then launches the sender with a one-cycle task
//  pulse, payload length and sequence number. Waits for the sender to finish, advances the TCP sequence
//  number by the bytes sent and reopens the input. Single payload buffer; no data is accepted while a frame is in flight.
// PARAMETERS
//  MAX_WORDS    256      payload words per packet, 1..(512-RAM_BASE)
//  RAM_BASE     2        RAM address of payload word 0 (sender read-pointer convention)
//  FLUSH_CYC    1024     idle cycles with a partial packet before forced flush; 0 disables
//  DONE_TMO     65535    cycles to wait for sender_valid edges before abort
// PORTS
//  clk            in   1   single clock; all logic on posedge
//  rst            in   1   synchronous, active-high reset
//  in_data        in   8   payload byte
//  in_valid       in   1   in_data valid
//  in_last        in   1   with in_valid: byte is last of packet, flush after it
//  in_ready       out  1   byte accepted when in_valid & in_ready
//  seq_load       in   1   load seq_init into sequence register (ignored unless FILL and packet empty)
//  seq_init       in   32  initial sequence number
//  ram_wr_en      out  1   payload RAM write strobe
//  ram_wr_addr    out  9   payload RAM write address
//  ram_wr_data    out  32  payload word, first byte in [31:24]
//  tx_task        out  1   one-cycle launch pulse to sender
//  tx_data_len    out  16  payload bytes of launched packet; stable from launch until next launch
//  tx_seq_num     out  32  sequence number of launched packet; stable likewise
//  sender_valid   in   1   sender idle flag (low while busy)
//  pkt_count      out  16  packets completed, wraps at 16'hFFFF->0
//  tx_abort       out  1   one-cycle pulse on DONE_TMO expiry
// BEHAVIOUR
//  Reset: state FILL, in_ready=1, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, tx_task=0, tx_data_len=0,
//   tx_seq_num=0, seq register=0, pkt_count=0, tx_abort=0, byte/word counters and flush timer=0.
//   Reset mid-packet discards the partial packet; no tx_task is issued.
//  States: FILL -> PAD -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> FILL.
//  FILL: in_ready=1. Accepted byte k of a word goes to lane [31-8k:24-8k]. On 4th byte, word is written
//   next cycle: ram_wr_en=1, ram_wr_addr=RAM_BASE+word_idx (9-bit), word_idx++. byte_cnt counts bytes.
//   Flush condition (evaluated on the accepting cycle): in_last, or byte_cnt reaches 4*MAX_WORDS, or flush
//   timer hits FLUSH_CYC with byte_cnt>0 (timer cleared on every accepted byte). Flush -> PAD, in_ready=0
//   the cycle after. Empty packet (byte_cnt=0) never flushes; in_last on no data is impossible (needs in_valid).
//  PAD: if a partial word exists, write it with unused low lanes zero (keeps sender checksum valid); 1 cycle.
//  LAUNCH: tx_data_len=byte_cnt (exact, not rounded), tx_seq_num=seq; tx_task=1 for exactly one cycle.
//  WAIT_BUSY: wait sender_valid=0. WAIT_DONE: wait sender_valid=1. Then seq += tx_data_len (mod 2^32),
//   pkt_count++, counters cleared, -> FILL with in_ready=1 next cycle.
//  Timeout: DONE_TMO cycles in either WAIT state -> tx_abort pulse, seq NOT advanced, pkt_count unchanged,
//   -> FILL, buffer discarded.
//  seq_load honoured only in FILL with byte_cnt=0; same-cycle accepted byte still packed normally.
//  Latency: last accepted byte -> tx_task = 3 cycles (write, pad/skip, launch) worst case.
//  tx_data_len <= 4*MAX_WORDS; sender adds 40 header bytes.
// TESTING
//  Reset, push 8 bytes 01..08 with in_last on 08 -> RAM[2]=01020304, RAM[3]=05060708, tx_data_len=8, tx_seq_num=0, 1 tx_task pulse.
//  Push 5 bytes AA..AE + in_last -> RAM[3]=AE000000, tx_data_len=5; after sender cycle seq=5, pkt_count=1.
//  MAX_WORDS=4, stream 20 bytes no last -> two packets 16 and 4(FLUSH_CYC) bytes; in_ready low during send.
//  seq_load with seq_init=FFFFFFFE, send 4 bytes -> tx_seq_num=FFFFFFFE, next seq=00000002 (wrap).
//  Hold sender_valid=1 after launch -> tx_abort after DONE_TMO, seq and pkt_count unchanged.
//  Assert rst during WAIT_DONE -> all outputs at reset values, next packet tx_seq_num=0.

Source files
------------

// File: rtl/tcp_payload_packer.sv
// Packs a byte stream big-endian into 32-bit payload words, fills the TCP
// sender's payload RAM, launches the sender and tracks the sequence number.
module tcp_payload_packer #(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned RAM_BASE  = 2,
  parameter int unsigned FLUSH_CYC = 1024,
  parameter int unsigned DONE_TMO  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        seq_load,
  input  logic [31:0] seq_init,
  output logic        ram_wr_en,
  output logic [8:0]  ram_wr_addr,
  output logic [31:0] ram_wr_data,
  output logic        tx_task,
  output logic [15:0] tx_data_len,
  output logic [31:0] tx_seq_num,
  input  logic        sender_valid,
  output logic [15:0] pkt_count,
  output logic        tx_abort
);

  localparam int unsigned MAX_BYTES = 4 * MAX_WORDS;

  typedef enum logic [2:0] {FILL, PAD, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      state, state_next;
  logic        accept, tmr_expire, tmo_expire, flush_now;
  logic [31:0] word_buf, word_merged;
  logic [15:0] byte_cnt;
  logic [8:0]  word_idx;
  logic [31:0] flush_tmr, tmo_cnt, seq;

  assign in_ready   = (state == FILL);
  assign accept     = in_valid & in_ready;
  assign tmr_expire = (FLUSH_CYC != 0) && !accept && (byte_cnt != '0) &&
                      (flush_tmr == 32'(FLUSH_CYC - 1));
  assign tmo_expire = (tmo_cnt == 32'(DONE_TMO - 1));
  assign flush_now  = (accept && (in_last || byte_cnt == 16'(MAX_BYTES - 1))) || tmr_expire;

  // Drop the incoming byte into its big-endian lane of the word being built.
  always_comb begin
    word_merged = word_buf;
    unique case (byte_cnt[1:0])
      2'd0: word_merged[31:24] = in_data;
      2'd1: word_merged[23:16] = in_data;
      2'd2: word_merged[15:8]  = in_data;
      2'd3: word_merged[7:0]   = in_data;
    endcase
  end

  // Next-state logic for the fill/launch/wait sequence.
  always_comb begin
    state_next = state;
    unique case (state)
      FILL:      if (flush_now) state_next = PAD;
      PAD:       state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: if (!sender_valid) state_next = WAIT_DONE;
                 else if (tmo_expire) state_next = FILL;
      WAIT_DONE: if (sender_valid || tmo_expire) state_next = FILL;
      default:   state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Datapath: packing, RAM writes, launch outputs, sequence and timers.
  // Completed words are written from FILL; PAD only writes a partial word,
  // so a byte count that is a multiple of 4 skips the PAD write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      tx_task     <= 1'b0;
      tx_data_len <= '0;
      tx_seq_num  <= '0;
      pkt_count   <= '0;
      tx_abort    <= 1'b0;
      word_buf    <= '0;
      byte_cnt    <= '0;
      word_idx    <= '0;
      flush_tmr   <= '0;
      tmo_cnt     <= '0;
      seq         <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      tx_task   <= 1'b0;
      tx_abort  <= 1'b0;
      unique case (state)
        FILL: begin
          if (seq_load && byte_cnt == '0) seq <= seq_init;
          if (accept) begin
            flush_tmr <= '0;
            byte_cnt  <= byte_cnt + 16'd1;
            if (byte_cnt[1:0] == 2'd3) begin
              ram_wr_en   <= 1'b1;
              ram_wr_addr <= 9'(RAM_BASE) + word_idx;
              ram_wr_data <= word_merged;
              word_idx    <= word_idx + 9'd1;
              word_buf    <= '0;
            end else begin
              word_buf <= word_merged;
            end
          end else if (byte_cnt != '0 && FLUSH_CYC != 0) begin
            flush_tmr <= flush_tmr + 32'd1;
          end
        end
        PAD: begin
          if (byte_cnt[1:0] != 2'd0) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= 9'(RAM_BASE) + word_idx;
            ram_wr_data <= word_buf;
          end
        end
        LAUNCH: begin
          tx_task     <= 1'b1;
          tx_data_len <= byte_cnt;
          tx_seq_num  <= seq;
          tmo_cnt     <= '0;
        end
        WAIT_BUSY: begin
          if (!sender_valid) tmo_cnt <= '0;
          else if (tmo_expire) begin
            tx_abort  <= 1'b1;
            word_buf  <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            flush_tmr <= '0;
          end else tmo_cnt <= tmo_cnt + 32'd1;
        end
        WAIT_DONE: begin
          if (sender_valid) begin
            seq       <= seq + {16'd0, tx_data_len};
            pkt_count <= pkt_count + 16'd1;
            word_buf  <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            flush_tmr <= '0;
          end else if (tmo_expire) begin
            tx_abort  <= 1'b1;
            word_buf  <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            flush_tmr <= '0;
          end else tmo_cnt <= tmo_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
